// File: rtl/mips_mc_pkg.sv
// Shared constants and enums for the multi-cycle MIPS-subset core.
package mips_mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   typedef enum logic [2:0] {
      C_ILL,
      C_ALU_R,
      C_ADDI,
      C_LW,
      C_SW,
      C_BEQ,
      C_BNE,
      C_J
   } inst_cls_t;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU shared by every instruction class; zero flags a null result.
module mc_alu
   import mips_mc_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  alu_op_t            op,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   output logic [DATA_W-1:0]  result,
   output logic               zero
);

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLT: result = DATA_W'($signed(a) < $signed(b));
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB around one shared ALU,
// with req/ack memories. Define MIPS_MC_BNE_EN to decode op 0x05 as BNE.
module mips_multicycle
   import mips_mc_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PC_W    = 5,
   parameter int REG_N   = 32,
   parameter int DADDR_W = 4
) (
   input  logic               clk,
   input  logic               counterRst,
   input  logic               counterLd,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic               dmem_ack,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic [PC_W-1:0]    pc,
   output logic               retired,
   output logic               illegal
);

   localparam int RA_W = $clog2(REG_N);

   state_t            state, state_nx;
   inst_cls_t         cls;
   alu_op_t           alu_op;
   logic [31:0]       ir;
   logic [DATA_W-1:0] regs [REG_N];
   logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
   logic [DATA_W-1:0] imm_ext, alu_b, alu_y, wb_data;
   logic              alu_zero;
   logic [RA_W-1:0]   rs, rt, rd, wr_addr;
   logic [PC_W-1:0]   target;
   logic              ir_ld, ab_ld, alu_ld, mdr_ld, reg_we, pc_inc, pc_jump;
   logic              req_i, req_d, we_d, ret_c, ill_c;
   logic              unused_shamt;

   assign rs      = ir[21 +: RA_W];
   assign rt      = ir[16 +: RA_W];
   assign rd      = ir[11 +: RA_W];
   assign imm_ext = DATA_W'(ir[15:0]);
   assign target  = ir[PC_W-1:0];
   assign unused_shamt = ^ir[10:6];

   always_comb begin
      cls    = C_ILL;
      alu_op = ALU_ADD;
      case (ir[31:26])
         OP_RTYPE: begin
            cls = C_ALU_R;
            case (ir[5:0])
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: cls = C_ILL;
            endcase
         end
         OP_ADDI: cls = C_ADDI;
         OP_LW:   cls = C_LW;
         OP_SW:   cls = C_SW;
         OP_BEQ: begin
            cls    = C_BEQ;
            alu_op = ALU_SUB;
         end
`ifdef MIPS_MC_BNE_EN
         OP_BNE: begin
            cls    = C_BNE;
            alu_op = ALU_SUB;
         end
`endif
         OP_J:    cls = C_J;
         default: cls = C_ILL;
      endcase
   end

   assign alu_b = (cls == C_ADDI || cls == C_LW || cls == C_SW) ? imm_ext : b_q;

   mc_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (alu_op),
      .a      (a_q),
      .b      (alu_b),
      .result (alu_y),
      .zero   (alu_zero)
   );

   always_comb begin
      state_nx = state;
      req_i = 1'b0; req_d = 1'b0; we_d = 1'b0; ret_c = 1'b0; ill_c = 1'b0;
      ir_ld = 1'b0; ab_ld = 1'b0; alu_ld = 1'b0; mdr_ld = 1'b0;
      reg_we = 1'b0; pc_inc = 1'b0; pc_jump = 1'b0;
      case (state)
         S_FETCH: begin
            if (counterLd) begin
               req_i = 1'b1;
               if (imem_ack) begin
                  ir_ld    = 1'b1;
                  pc_inc   = 1'b1;
                  state_nx = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            ab_ld = 1'b1;
            if (cls == C_ILL) begin
               ill_c    = 1'b1;
               ret_c    = 1'b1;
               state_nx = S_FETCH;
            end else begin
               state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_ld = 1'b1;
            case (cls)
               C_J, C_BEQ, C_BNE: begin
                  pc_jump  = (cls == C_J) | ((cls == C_BEQ) & alu_zero) | ((cls == C_BNE) & ~alu_zero);
                  ret_c    = 1'b1;
                  state_nx = S_FETCH;
               end
               C_LW, C_SW: state_nx = S_MEM;
               default:    state_nx = S_WB;
            endcase
         end
         S_MEM: begin
            req_d = 1'b1;
            we_d  = (cls == C_SW);
            if (dmem_ack) begin
               if (cls == C_SW) begin
                  ret_c    = 1'b1;
                  state_nx = S_FETCH;
               end else begin
                  mdr_ld   = 1'b1;
                  state_nx = S_WB;
               end
            end
         end
         S_WB: begin
            reg_we   = 1'b1;
            ret_c    = 1'b1;
            state_nx = S_FETCH;
         end
         default: state_nx = S_FETCH;
      endcase
   end

   // Reset is synchronous for state, but outstanding requests are dropped in the reset cycle itself.
   assign imem_req = req_i & ~counterRst;
   assign dmem_req = req_d & ~counterRst;
   assign dmem_we  = we_d  & ~counterRst;
   assign retired  = ret_c & ~counterRst;
   assign illegal  = ill_c & ~counterRst;

   assign imem_addr  = pc;
   assign dmem_addr  = alu_q[DADDR_W-1:0];
   assign dmem_wdata = b_q;
   assign wb_data    = (cls == C_LW) ? mdr_q : alu_q;
   assign wr_addr    = (cls == C_ALU_R) ? rd : rt;

   always_ff @(posedge clk) begin
      if (counterRst) begin
         state <= S_FETCH;
         pc    <= '0;
         ir    <= '0;
         a_q   <= '0;
         b_q   <= '0;
         alu_q <= '0;
         mdr_q <= '0;
         regs  <= '{default: '0};
      end else begin
         state <= state_nx;
         if (ir_ld)  ir <= imem_rdata;
         if (pc_jump)     pc <= target;
         else if (pc_inc) pc <= pc + PC_W'(1);
         if (ab_ld) begin
            a_q <= regs[rs];
            b_q <= regs[rt];
         end
         if (alu_ld) alu_q <= alu_y;
         if (mdr_ld) mdr_q <= dmem_rdata;
         if (reg_we && wr_addr != '0) regs[wr_addr] <= wb_data;
      end
   end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: ISA-level reference model plus directed and random programs.
module tb_mips_multicycle;

   localparam int DATA_W  = 32;
   localparam int PC_W    = 5;
   localparam int REG_N   = 32;
   localparam int DADDR_W = 4;
`ifdef MIPS_MC_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif
   localparam int K_ILL = 0, K_BR = 1, K_ALU = 2, K_SW = 3, K_LW = 4;

   logic               clk = 1'b0;
   logic               counterRst = 1'b1;
   logic               counterLd = 1'b0;
   logic               imem_req, imem_ack = 1'b0;
   logic [PC_W-1:0]    imem_addr, pc;
   logic [31:0]        imem_rdata = '0;
   logic               dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [DADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0]  dmem_wdata, dmem_rdata = '0;
   logic               retired, illegal;

   always #5 clk = ~clk;

   mips_multicycle #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_N(REG_N), .DADDR_W(DADDR_W)) dut (
      .clk        (clk),
      .counterRst (counterRst),
      .counterLd  (counterLd),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .pc         (pc),
      .retired    (retired),
      .illegal    (illegal)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // environment memories and wait-state settings
   logic [31:0]       imem [32];
   logic [DATA_W-1:0] dmem [16];
   int  i_wait = 0, d_wait = 0;
   bit  rand_w = 1'b0;
   int  iw, itg, dw, dtg;
   bit  ia = 1'b0, da = 1'b0;

   initial begin
      forever begin
         @(posedge clk); #2;
         if (imem_req) begin
            if (!ia) begin ia = 1'b1; iw = 0; itg = rand_w ? int'($urandom_range(0, 3)) : i_wait; end
            if (iw >= itg) begin imem_ack = 1'b1; imem_rdata = imem[imem_addr]; ia = 1'b0; end
            else begin imem_ack = 1'b0; imem_rdata = $urandom; iw++; end
         end else begin
            ia = 1'b0; imem_ack = ($urandom_range(0, 3) == 0); imem_rdata = $urandom;
         end
         if (dmem_req) begin
            if (!da) begin da = 1'b1; dw = 0; dtg = rand_w ? int'($urandom_range(0, 3)) : d_wait; end
            if (dw >= dtg) begin
               dmem_ack = 1'b1;
               if (dmem_we) dmem[dmem_addr] = dmem_wdata;
               dmem_rdata = dmem[dmem_addr];
               da = 1'b0;
            end else begin dmem_ack = 1'b0; dmem_rdata = $urandom; dw++; end
         end else begin
            da = 1'b0; dmem_ack = ($urandom_range(0, 3) == 0); dmem_rdata = $urandom;
         end
      end
   end

   // architectural reference model
   logic [DATA_W-1:0]  m_r [REG_N];
   logic [DATA_W-1:0]  m_dm [16];
   logic [PC_W-1:0]    m_pc = '0;
   int                 kind, fa, exp_ret, since = 0;
   int unsigned        dest;
   logic [DATA_W-1:0]  res, sdata;
   logic [DADDR_W-1:0] eaddr;
   logic [PC_W-1:0]    tgt;
   bit                 take, busy = 1'b0, mem_done, dexp;
   int                 ret_log[$];
   int                 st_addr[$];
   longint unsigned    st_data[$];

   task automatic predict(input logic [31:0] w);
      logic [DATA_W-1:0] a, b, imm, sum;
      a = m_r[w[25:21]]; b = m_r[w[20:16]]; imm = DATA_W'(w[15:0]);
      sum = a + imm;
      kind = K_ILL; dest = 0; res = '0; take = 1'b0; tgt = w[PC_W-1:0];
      eaddr = sum[DADDR_W-1:0]; sdata = b;
      case (w[31:26])
         6'h00: begin
            kind = K_ALU; dest = w[15:11];
            case (w[5:0])
               6'h20: res = a + b;
               6'h22: res = a - b;
               6'h24: res = a & b;
               6'h25: res = a | b;
               6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
               default: kind = K_ILL;
            endcase
         end
         6'h08: begin kind = K_ALU; dest = w[20:16]; res = sum; end
         6'h23: begin kind = K_LW; dest = w[20:16]; end
         6'h2B: kind = K_SW;
         6'h04: begin kind = K_BR; take = (a == b); end
         6'h05: if (BNE_EN) begin kind = K_BR; take = (a != b); end
         6'h02: begin kind = K_BR; take = 1'b1; end
         default: kind = K_ILL;
      endcase
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (counterRst) begin
            chk("rst_outputs", {imem_req, dmem_req, dmem_we, retired, illegal}, 0);
            since = 0; busy = 1'b0; m_pc = '0;
            for (int i = 0; i < REG_N; i++) m_r[i] = '0;
            ret_log.delete(); st_addr.delete(); st_data.delete();
         end else begin
            since++;
            chk("pc", pc, m_pc);
            if (retired) ret_log.push_back(since);
            if (!busy) begin
               chk("imem_req_idle", imem_req, counterLd);
               chk("idle_outputs", {dmem_req, retired, illegal}, 0);
               if (imem_req) chk("imem_addr", imem_addr, m_pc);
               if (imem_req && imem_ack) begin
                  predict(imem[m_pc]);
                  busy = 1'b1; fa = since; mem_done = 1'b0; m_pc = m_pc + 1'b1;
                  exp_ret = (kind == K_ILL) ? fa + 1 : (kind == K_BR) ? fa + 2 : (kind == K_ALU) ? fa + 3 : -1;
               end
            end else begin
               dexp = (kind == K_LW || kind == K_SW) && since >= fa + 3 && !mem_done;
               chk("imem_req_busy", imem_req, 0);
               chk("dmem_req", dmem_req, dexp);
               if (dmem_req) begin
                  chk("dmem_we", dmem_we, kind == K_SW);
                  chk("dmem_addr", dmem_addr, eaddr);
                  if (kind == K_SW) chk("dmem_wdata", dmem_wdata, sdata);
               end
               if (dmem_req && dmem_ack) begin
                  mem_done = 1'b1;
                  if (kind == K_SW) begin
                     exp_ret = since; m_dm[eaddr] = sdata;
                     st_addr.push_back(int'(eaddr)); st_data.push_back(sdata);
                  end else begin
                     exp_ret = since + 1; res = m_dm[eaddr];
                  end
               end
               chk("retired", retired, since == exp_ret);
               chk("illegal", illegal, kind == K_ILL && since == exp_ret);
               if (since == exp_ret) begin
                  if ((kind == K_ALU || kind == K_LW) && dest != 0) m_r[dest] = res;
                  if (kind == K_BR && take) m_pc = tgt;
                  busy = 1'b0;
               end else if (since - fa > 60) begin
                  checks++; errors++;
                  $display("FAIL instr_timeout: %0d cycles without retire, expected under 60", since - fa);
                  busy = 1'b0;
               end
            end
         end
      end
   end

   function automatic int rl(input int i);
      return (i < ret_log.size()) ? ret_log[i] : -1;
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [4:0]  s, t, d;
      logic [15:0] im;
      logic [5:0]  fn;
      s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
      im = 16'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
         0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; default: fn = 6'h2A;
      endcase
      case ($urandom_range(0, 10))
         0, 1:    return {6'h00, s, t, d, 5'd0, fn};
         2:       return {6'h08, s, t, ($urandom_range(0, 1) != 0) ? 16'($urandom) : im};
         3:       return {6'h23, s, t, im};
         4, 5:    return {6'h2B, s, t, im};
         6:       return {6'h04, s, t, 11'd0, 5'($urandom)};
         7:       return {6'h05, s, t, 11'd0, 5'($urandom)};
         8:       return {6'h02, 21'd0, 5'($urandom)};
         9:       return {6'h00, s, t, d, 5'd0, 6'h21};
         default: return {6'h3F, 26'($urandom)};
      endcase
   endfunction

   task automatic init_dmem();
      for (int i = 0; i < 16; i++) begin
         dmem[i] = $urandom;
         m_dm[i] = dmem[i];
      end
   endtask

   task automatic load_directed();
      for (int i = 0; i < 32; i++) imem[i] = '0;
      imem[0]  = {6'h08, 5'd0, 5'd1, 16'd5};
      imem[1]  = {6'h08, 5'd0, 5'd2, 16'd7};
      imem[2]  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
      imem[3]  = {6'h2B, 5'd0, 5'd3, 16'd2};
      imem[4]  = {6'h23, 5'd0, 5'd4, 16'd2};
      imem[5]  = {6'h2B, 5'd0, 5'd4, 16'd3};
      imem[6]  = {6'h04, 5'd1, 5'd1, 16'h001F};
      imem[31] = {6'h08, 5'd0, 5'd5, 16'd9};
   endtask

   task automatic do_reset();
      @(posedge clk); #1 counterRst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 counterRst = 1'b0;
   endtask

   bit found;

   initial begin
      // zero-wait directed program
      init_dmem(); load_directed();
      counterLd = 1'b1;
      do_reset();
      repeat (29) @(negedge clk);
      chk("beq_pc_target", pc, 5'h1F);
      @(negedge clk);
      chk("pc_wrap", pc, 0);
      repeat (10) @(negedge clk);
      @(posedge clk); #1 counterLd = 1'b0;
      repeat (8) @(negedge clk);
      @(posedge clk); #1 counterLd = 1'b1;
      repeat (10) @(negedge clk);
      chk("ret_cycle0", rl(0), 4);
      chk("ret_cycle1", rl(1), 8);
      chk("ret_cycle2", rl(2), 12);
      chk("sw_ret_cycle", rl(3), 16);
      chk("lw_len", rl(4) - rl(3), 5);
      chk("beq_ret_cycle", rl(6), 28);
      chk("sw_addr", (st_addr.size() > 0) ? st_addr[0] : -1, 2);
      chk("sw_data", (st_data.size() > 0) ? st_data[0] : 64'hDEAD, 12);
      chk("lw_to_sw_data", (st_data.size() > 1) ? st_data[1] : 64'hDEAD, 12);

      // wait-state memories
      i_wait = 3; d_wait = 2;
      do_reset();
      for (int n = 0; n < 200 && ret_log.size() < 5; n++) @(negedge clk);
      chk("ws_first_ret", rl(0), 7);
      chk("ws_lw_len", rl(4) - rl(3), 10);

      // reset while a data request is outstanding
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(posedge clk); #1;
         if (dmem_req) begin counterRst = 1'b1; found = 1'b1; end
      end
      chk("rst_mid_mem_found", found, 1);
      @(negedge clk);
      chk("rst_drop_dmem_req", dmem_req, 0);
      imem[0] = {6'h2B, 5'd0, 5'd3, 16'd5};
      @(posedge clk); #1 counterRst = 1'b0;
      @(negedge clk);
      chk("post_rst_pc", pc, 0);
      chk("post_rst_dmem_req", dmem_req, 0);
      chk("post_rst_imem_req", imem_req, 1);
      for (int n = 0; n < 100 && st_data.size() < 1; n++) @(negedge clk);
      chk("post_rst_reg_zero", (st_data.size() > 0) ? st_data[0] : 64'hDEAD, 0);
      chk("post_rst_st_addr", (st_addr.size() > 0) ? st_addr[0] : -1, 5);

      // op 0x05 handling
      for (int i = 0; i < 32; i++) imem[i] = '0;
      imem[0] = {6'h08, 5'd0, 5'd1, 16'd1};
      imem[1] = {6'h05, 5'd1, 5'd0, 16'h0010};
      i_wait = 0; d_wait = 0;
      do_reset();
      repeat (6) @(negedge clk);
      chk("op05_illegal", illegal, !BNE_EN);
      @(negedge clk);
      chk("op05_pc_adv", pc, 2);
      @(negedge clk);
      chk("op05_pc_next", pc, BNE_EN ? 16 : 3);

      // random programs with random wait states and run-enable gaps
      for (int i = 0; i < 32; i++) imem[i] = rnd_inst();
      init_dmem();
      rand_w = 1'b1;
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         @(posedge clk); #1;
         if (counterLd && $urandom_range(0, 31) == 0) counterLd = 1'b0;
         else if (!counterLd && $urandom_range(0, 3) == 0) counterLd = 1'b1;
         if (n == 2000) for (int i = 0; i < 32; i++) imem[i] = rnd_inst();
      end
      @(posedge clk); #1 counterLd = 1'b0;
      repeat (80) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
